// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline boundary: result select, buffered writeback entries and a sticky address-exception report.
// Define MEMWB_SKID_EN to get a 2-entry skid FIFO with a registered mem_ready; the default build holds one entry.
module pipe_mem_wb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic             mem_jal,
    input  logic [4:0]       mem_rn,
    input  logic [WIDTH-1:0] mem_alu,
    input  logic [WIDTH-1:0] mem_mdata,
    input  logic [WIDTH-1:0] mem_pc8,
    input  logic             mem_adderr,
    input  logic             flush,
    input  logic             wb_ready,
    output logic             wb_valid,
    output logic             wb_wreg,
    output logic [4:0]       wb_rn,
    output logic [WIDTH-1:0] wb_data,
    output logic             exc_adderr,
    output logic [WIDTH-1:0] exc_badaddr,
    input  logic             exc_ack
);

    typedef struct packed {
        logic             wreg;
        logic [4:0]       rn;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t new_entry;
    entry_t head_q;
    logic   push;
    logic   pop;
    logic   err_push;

    // A faulting access must never write the register file, but it still travels down the pipe.
    always_comb begin
        new_entry.wreg = mem_wreg && !mem_adderr;
        new_entry.rn   = mem_rn;
        if (mem_jal)
            new_entry.data = mem_pc8;
        else if (mem_m2reg)
            new_entry.data = mem_mdata;
        else
            new_entry.data = mem_alu;
    end

    assign push = mem_valid && mem_ready;
    assign pop  = wb_valid && wb_ready;

`ifdef MEMWB_SKID_EN
    entry_t     tail_q;
    logic [1:0] count_q;
    logic       ready_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b1;
        end else if (flush) begin
            count_q <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= new_entry;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (push) begin
                        tail_q  <= new_entry;
                        count_q <= 2'd2;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    // Full: mem_ready is low, so only a pop can happen here.
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem_ready = ready_q;
    assign wb_valid  = (count_q != 2'd0);
`else
    logic valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (push) begin
            head_q  <= new_entry;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    // Pass-through: a pop frees the single slot in the same cycle it is refilled.
    assign mem_ready = !valid_q || wb_ready;
    assign wb_valid  = valid_q;
`endif

    assign wb_wreg = head_q.wreg;
    assign wb_rn   = head_q.rn;
    assign wb_data = head_q.data;

    // A push killed by flush never reaches writeback, so it cannot raise an exception either.
    assign err_push = push && mem_adderr && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_adderr  <= 1'b0;
            exc_badaddr <= '0;
        end else if (err_push && (!exc_adderr || exc_ack)) begin
            exc_adderr  <= 1'b1;
            exc_badaddr <= mem_alu;
        end else if (exc_ack) begin
            exc_adderr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Directed bench for pipe_mem_wb; covers both the single-entry build and the MEMWB_SKID_EN build.
module tb_pipe_mem_wb;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_valid;
    logic             mem_ready;
    logic             mem_wreg;
    logic             mem_m2reg;
    logic             mem_jal;
    logic [4:0]       mem_rn;
    logic [WIDTH-1:0] mem_alu;
    logic [WIDTH-1:0] mem_mdata;
    logic [WIDTH-1:0] mem_pc8;
    logic             mem_adderr;
    logic             flush;
    logic             wb_ready;
    logic             wb_valid;
    logic             wb_wreg;
    logic [4:0]       wb_rn;
    logic [WIDTH-1:0] wb_data;
    logic             exc_adderr;
    logic [WIDTH-1:0] exc_badaddr;
    logic             exc_ack;

    int vectors = 0;
    int miscompares = 0;

    pipe_mem_wb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_jal(mem_jal),
        .mem_rn(mem_rn), .mem_alu(mem_alu), .mem_mdata(mem_mdata), .mem_pc8(mem_pc8),
        .mem_adderr(mem_adderr), .flush(flush), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
        .exc_adderr(exc_adderr), .exc_badaddr(exc_badaddr), .exc_ack(exc_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary, got running want finished");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_jal = 1'b0;
        mem_rn = '0; mem_alu = '0; mem_mdata = '0; mem_pc8 = '0;
        mem_adderr = 1'b0; flush = 1'b0; exc_ack = 1'b0; wb_ready = 1'b1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] alu, input logic [4:0] rn, input logic wreg,
                         input logic m2reg, input logic jal, input logic [WIDTH-1:0] mdata,
                         input logic [WIDTH-1:0] pc8, input logic adderr);
        mem_valid = 1'b1; mem_alu = alu; mem_rn = rn; mem_wreg = wreg;
        mem_m2reg = m2reg; mem_jal = jal; mem_mdata = mdata; mem_pc8 = pc8; mem_adderr = adderr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL reset_wb_valid got %0b want 0", wb_valid); miscompares++; end
        vectors++; if (wb_data !== '0) begin $display("FAIL reset_wb_data got %h want 0", wb_data); miscompares++; end
        vectors++; if (exc_adderr !== 1'b0) begin $display("FAIL reset_exc_adderr got %0b want 0", exc_adderr); miscompares++; end
        @(negedge clk);
        rst = 1'b0;
        step();
        vectors++; if (mem_ready !== 1'b1) begin $display("FAIL reset_mem_ready got %0b want 1", mem_ready); miscompares++; end
    endtask

    task automatic test_basic_push();
        drive(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        mem_valid = 1'b0;
        vectors++; if (wb_valid !== 1'b1) begin $display("FAIL basic_valid got %0b want 1", wb_valid); miscompares++; end
        vectors++; if (wb_data !== 32'h10) begin $display("FAIL basic_data got %h want 00000010", wb_data); miscompares++; end
        vectors++; if (wb_rn !== 5'd5) begin $display("FAIL basic_rn got %0d want 5", wb_rn); miscompares++; end
        vectors++; if (wb_wreg !== 1'b1) begin $display("FAIL basic_wreg got %0b want 1", wb_wreg); miscompares++; end
        step();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL basic_drain got %0b want 0", wb_valid); miscompares++; end
    endtask

    task automatic test_result_select();
        drive(32'h55, 5'd31, 1'b1, 1'b1, 1'b1, 32'hAA, 32'h408, 1'b0);
        step();
        vectors++; if (wb_data !== 32'h408) begin $display("FAIL sel_jal got %h want 00000408", wb_data); miscompares++; end
        // Push while the head pops: the load result replaces it.
        drive(32'h55, 5'd2, 1'b1, 1'b1, 1'b0, 32'hAA, 32'h408, 1'b0);
        step();
        vectors++; if (wb_data !== 32'hAA) begin $display("FAIL sel_m2reg got %h want 000000aa", wb_data); miscompares++; end
        vectors++; if (wb_valid !== 1'b1) begin $display("FAIL sel_b2b_valid got %0b want 1", wb_valid); miscompares++; end
        mem_valid = 1'b0;
        step();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL sel_drain got %0b want 0", wb_valid); miscompares++; end
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        drive(32'h21, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
`ifdef MEMWB_SKID_EN
        drive(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        mem_valid = 1'b0;
        vectors++; if (mem_ready !== 1'b0) begin $display("FAIL skid_full_ready got %0b want 0", mem_ready); miscompares++; end
        step();
        vectors++; if (wb_data !== 32'h21) begin $display("FAIL skid_hold got %h want 00000021", wb_data); miscompares++; end
        wb_ready = 1'b1;
        step();
        vectors++; if (wb_data !== 32'h22) begin $display("FAIL skid_second got %h want 00000022", wb_data); miscompares++; end
        vectors++; if (mem_ready !== 1'b1) begin $display("FAIL skid_ready_after_pop got %0b want 1", mem_ready); miscompares++; end
        step();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL skid_drain got %0b want 0", wb_valid); miscompares++; end
`else
        drive(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        vectors++; if (mem_ready !== 1'b0) begin $display("FAIL stall_ready got %0b want 0", mem_ready); miscompares++; end
        step();
        vectors++; if (wb_data !== 32'h21) begin $display("FAIL stall_hold got %h want 00000021", wb_data); miscompares++; end
        vectors++; if (wb_rn !== 5'd1) begin $display("FAIL stall_hold_rn got %0d want 1", wb_rn); miscompares++; end
        wb_ready = 1'b1;
        #1;
        vectors++; if (mem_ready !== 1'b1) begin $display("FAIL stall_release_ready got %0b want 1", mem_ready); miscompares++; end
        step();
        mem_valid = 1'b0;
        vectors++; if (wb_data !== 32'h22) begin $display("FAIL stall_replace got %h want 00000022", wb_data); miscompares++; end
        step();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL stall_drain got %0b want 0", wb_valid); miscompares++; end
`endif
    endtask

    task automatic test_adderr();
        drive(32'h3, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        vectors++; if (wb_wreg !== 1'b0) begin $display("FAIL err_wreg got %0b want 0", wb_wreg); miscompares++; end
        vectors++; if (wb_valid !== 1'b1) begin $display("FAIL err_valid got %0b want 1", wb_valid); miscompares++; end
        vectors++; if (exc_adderr !== 1'b1) begin $display("FAIL err_flag got %0b want 1", exc_adderr); miscompares++; end
        vectors++; if (exc_badaddr !== 32'h3) begin $display("FAIL err_badaddr got %h want 00000003", exc_badaddr); miscompares++; end
        drive(32'h7, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        vectors++; if (exc_badaddr !== 32'h3) begin $display("FAIL err_first_wins got %h want 00000003", exc_badaddr); miscompares++; end
        vectors++; if (wb_data !== 32'h7) begin $display("FAIL err_second_entry got %h want 00000007", wb_data); miscompares++; end
        idle();
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        vectors++; if (exc_adderr !== 1'b0) begin $display("FAIL err_ack_clear got %0b want 0", exc_adderr); miscompares++; end
        step();
        drive(32'hB, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        vectors++; if (exc_badaddr !== 32'hB) begin $display("FAIL err_recapture got %h want 0000000b", exc_badaddr); miscompares++; end
        drive(32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        exc_ack = 1'b1;
        step();
        vectors++; if (exc_adderr !== 1'b1) begin $display("FAIL err_ack_new_flag got %0b want 1", exc_adderr); miscompares++; end
        vectors++; if (exc_badaddr !== 32'hC) begin $display("FAIL err_ack_new_addr got %h want 0000000c", exc_badaddr); miscompares++; end
        idle();
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        step();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL err_drain got %0b want 0", wb_valid); miscompares++; end
    endtask

    task automatic test_flush();
        wb_ready = 1'b0;
        drive(32'h44, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
`ifdef MEMWB_SKID_EN
        drive(32'h45, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        vectors++; if (mem_ready !== 1'b0) begin $display("FAIL flush_full_ready got %0b want 0", mem_ready); miscompares++; end
`endif
        drive(32'h55, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        flush = 1'b1;
        wb_ready = 1'b1;
        step();
        idle();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL flush_valid got %0b want 0", wb_valid); miscompares++; end
        vectors++; if (mem_ready !== 1'b1) begin $display("FAIL flush_ready got %0b want 1", mem_ready); miscompares++; end
        vectors++; if (exc_adderr !== 1'b1) begin $display("FAIL flush_keeps_exc got %0b want 1", exc_adderr); miscompares++; end
        vectors++; if (exc_badaddr !== 32'h44) begin $display("FAIL flush_keeps_addr got %h want 00000044", exc_badaddr); miscompares++; end
        step();
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL flush_no_emit got %0b want 0", wb_valid); miscompares++; end
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(32'h99, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        wb_ready = 1'b0;
        step();
        vectors++; if (wb_valid !== 1'b1) begin $display("FAIL areset_pre_valid got %0b want 1", wb_valid); miscompares++; end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({wb_valid, wb_wreg} !== 2'b00) begin $display("FAIL areset_flags got %b want 00", {wb_valid, wb_wreg}); miscompares++; end
        vectors++; if (wb_rn !== 5'd0) begin $display("FAIL areset_rn got %0d want 0", wb_rn); miscompares++; end
        vectors++; if (wb_data !== '0) begin $display("FAIL areset_data got %h want 0", wb_data); miscompares++; end
        vectors++; if (exc_adderr !== 1'b0) begin $display("FAIL areset_exc got %0b want 0", exc_adderr); miscompares++; end
        vectors++; if (exc_badaddr !== '0) begin $display("FAIL areset_badaddr got %h want 0", exc_badaddr); miscompares++; end
        idle();
        @(negedge clk);
        rst = 1'b0;
        step();
        vectors++; if (mem_ready !== 1'b1) begin $display("FAIL areset_ready got %0b want 1", mem_ready); miscompares++; end
        vectors++; if (wb_valid !== 1'b0) begin $display("FAIL areset_post_valid got %0b want 0", wb_valid); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_result_select();
        test_back_to_back();
        test_adderr();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
